// File: rtl/priority_arb_v.sv
// Registered N-way arbiter with fixed-priority or round-robin selection.
// The grant is held on a valid/ready handshake until the consumer accepts it.
module priority_arb_v #(
  parameter int N = 4,
  parameter int RR = 0,
  localparam int W = $clog2(N)
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [N-1:0] i_req,
  input  logic         i_ready,
  output logic         o_valid,
  output logic [W-1:0] o_code,
  output logic [N-1:0] o_grant,
  output logic [W-1:0] o_ptr
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t state_q, state_d;
  logic [W-1:0] code_q, code_d;
  logic [N-1:0] grant_q, grant_d;
  logic [W-1:0] ptr_q, ptr_d;

  logic         accept;
  logic         lo_any;
  logic         hi_any;
  logic [W-1:0] lo_win;
  logic [W-1:0] hi_win;
  logic [W-1:0] win;

  // Search starts at the post-accept pointer so back-to-back grants rotate.
  always_comb begin
    accept = (state_q == GRANT) && i_ready;
    ptr_d  = ptr_q;
    if (accept && (RR != 0)) begin
      ptr_d = (code_q == W'(N - 1)) ? '0 : code_q + W'(1);
    end
    lo_any = |i_req;
    hi_any = 1'b0;
    lo_win = '0;
    hi_win = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (i_req[k]) begin
        lo_win = W'(k);
        if (W'(k) >= ptr_d) begin
          hi_win = W'(k);
          hi_any = 1'b1;
        end
      end
    end
    win = hi_any ? hi_win : lo_win;
  end

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    grant_d = grant_q;
    unique case (state_q)
      IDLE: begin
        if (lo_any) begin
          state_d      = GRANT;
          code_d       = win;
          grant_d      = '0;
          grant_d[win] = 1'b1;
        end
      end
      GRANT: begin
        if (accept) begin
          if (lo_any) begin
            code_d       = win;
            grant_d      = '0;
            grant_d[win] = 1'b1;
          end else begin
            state_d = IDLE;
            grant_d = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      code_q  <= '0;
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  assign o_valid = (state_q == GRANT);
  assign o_code  = code_q;
  assign o_grant = grant_q;
  assign o_ptr   = ptr_q;

endmodule

// File: doc/priority_arb_v.md
Name: priority_arb_v

Overview:
Parametrised, registered successor to the 4-to-2 priority encoder. It arbitrates among N request lines and presents the winning index as a binary code with a valid/ready handshake. Two selection modes are available: fixed priority (line 0 highest) and round-robin. The grant is held stable until the consumer accepts it. It sits between N request sources and a single shared resource or consumer in the datapath.

Parameters:
N, 4, number of request lines; legal range 2..64, need not be a power of 2.
RR, 0, selection mode: 0 = fixed priority (lowest index wins), 1 = round-robin.
W, $clog2(N), code width; derived localparam, not overridable.

Ports:
i_clk  input  1  single clock; all state updates on the rising edge.
i_rst  input  1  synchronous, active-high reset.
i_req  input  N  request lines; bit k = requester k.
i_ready  input  1  consumer accepts the current grant when high while o_valid is high.
o_valid  output  1  a grant is being presented.
o_code  output  W  binary index of the granted requester.
o_grant  output  N  one-hot form of o_code; all zeros when o_valid=0.
o_ptr  output  W  round-robin search start index (debug/observability); always 0 when RR=0.

Behaviour:
- Reset: one clock, synchronous, active-high; the only reset mechanism.
- Reset values: o_valid=0, o_code=0, o_grant=0, o_ptr=0, state=IDLE.
- Reset asserted in any state, including mid-grant, wins over all other inputs. No accept is recorded for that cycle.
- All outputs are registered; there are no combinational paths from any input to any output.
- State IDLE (o_valid=0):
  - If i_req != 0, select a winner per the mode rule. On the next edge go to GRANT with o_code=winner, o_grant=1<<winner, o_valid=1. Latency from request to grant is 1 cycle.
  - If i_req == 0, stay in IDLE.
- State GRANT (o_valid=1):
  - While i_ready=0, o_code, o_grant and o_valid hold unchanged, even if i_req changes or the granted requester deasserts. Deassertion does not revoke a grant.
  - Accept occurs when o_valid=1 and i_ready=1 in the same cycle.
  - On accept with RR=1: o_ptr <= (o_code+1) mod N. Wrap from N-1 to 0 applies for any N, including non-power-of-2.
  - On accept, if i_req != 0 in the same cycle, select a new winner from that cycle's i_req and stay in GRANT. This gives back-to-back grants with no bubble.
  - Back-to-back selection in RR=1 uses the post-update pointer, i.e. the search starts at (old o_code+1) mod N.
  - On accept with i_req == 0, go to IDLE and clear o_valid and o_grant. o_code retains its last value.
- Selection rule, RR=0: lowest set index of i_req. The same requester may win repeatedly.
- Selection rule, RR=1:
  - Winner is the first set bit of i_req scanning o_ptr, o_ptr+1, ..., N-1, 0, ..., o_ptr-1.
  - The pointer changes only on accept, never on grant issue.
- i_ready high while o_valid=0 has no effect.
- i_req bits at index >= N do not exist; all of o_code's W bits are always < N.

Test Plan:
- Reset and idle: N=4, RR=0. Assert i_rst for 2 cycles with i_req=4'b1111 -> o_valid=0, o_grant=0, o_code=0 throughout. Then i_rst=0, i_req=0 for 3 cycles -> outputs stay 0.
- Fixed priority and hold: RR=0. i_req=4'b1010, i_ready=0 -> one cycle later o_valid=1, o_code=1, o_grant=4'b0010. Change i_req to 4'b0001 for 4 cycles -> o_code stays 1. Pulse i_ready=1 -> next cycle o_code=0, o_grant=4'b0001.
- Round-robin rotation: RR=1, i_req=4'b1111, i_ready=1 held -> successive grants o_code=0,1,2,3,0 on consecutive cycles with no bubble. o_ptr reads 1,2,3,0,1.
- Round-robin skip and wrap: N=5, RR=1, o_ptr=3 (after accepting code 2), i_req=5'b00101 -> o_code=0 on the next grant, because index 4 is unset and the search wraps.
- Accept to empty: single i_req=4'b0100 pulse, i_ready=1 on grant -> o_code=2 for exactly 1 cycle, then o_valid=0 and o_grant=0 while o_code remains 2.
- Reset mid-grant: o_valid=1, o_code=3, RR=1, o_ptr=2. Assert i_rst with i_ready=1 -> next cycle o_valid=0, o_code=0, o_ptr=0, and no pointer advance is recorded.
